// File: rtl/ram_sync_clr_if.sv
// Request/response bundle for ram_sync_clr: master drives cs/we/addr/din,
// the RAM returns registered dout with a valid strobe and a busy flag.
interface ram_sync_clr_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 4
);
   logic              cs;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              valid;
   logic              busy;

   modport master (
      output cs, we, addr, din,
      input  dout, valid, busy
   );

   modport slave (
      input  cs, we, addr, din,
      output dout, valid, busy
   );
endinterface

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM that zeroes every word after reset; reads return after 1 cycle
// with a valid strobe, and requests presented while busy (reset/clear) are dropped.
module ram_sync_clr #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic            clk,
   input  logic            reset,
   ram_sync_clr_if.slave   bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              in_range;
   logic [IDX_W-1:0]  req_idx;

   // Widened compare so DEPTH == 2**ADDR_W does not overflow the address width.
   assign in_range = ({1'b0, bus.addr} < (ADDR_W+1)'(DEPTH));
   assign req_idx  = bus.addr[IDX_W-1:0];

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      dout_d    = dout_q;
      valid_d   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = req_idx;
      mem_wdata = bus.din;

      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q[IDX_W-1:0];
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d   = IDLE;
               clr_cnt_d = '0;
            end
         end
         IDLE: begin
            if (bus.cs) begin
               if (bus.we) begin
                  mem_we = in_range;
               end else begin
                  valid_d = 1'b1;
                  dout_d  = in_range ? mem[req_idx] : '0;
               end
            end
         end
         default: state_d = CLEAR;
      endcase

      // Reset freezes the clear pointer at word 0, so nothing may be written.
      if (reset) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.valid = valid_q;
   assign bus.busy  = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed plus random stimulus for ram_sync_clr, checked every cycle against a
// transaction-level model of the memory, clear countdown and read strobe.
module tb_ram_sync_clr;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 4;
   localparam int DEPTH  = 16;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ram_sync_clr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_sync_clr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: memory contents, edges of clearing still owed, and output registers.
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int                ref_clr_left;
   logic [DATA_W-1:0] ref_dout;
   logic              ref_valid;

   task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic c, input logic w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input string tag);
      reset    = r;
      bus.cs   = c;
      bus.we   = w;
      bus.addr = a;
      bus.din  = d;

      if (r) begin
         ref_clr_left = DEPTH;
         ref_dout     = '0;
         ref_valid    = 1'b0;
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else if (ref_clr_left > 0) begin
         ref_clr_left--;
         ref_valid = 1'b0;
      end else if (c && w) begin
         if (int'(a) < DEPTH) ref_mem[a] = d;
         ref_valid = 1'b0;
      end else if (c) begin
         ref_dout  = (int'(a) < DEPTH) ? ref_mem[a] : '0;
         ref_valid = 1'b1;
      end else begin
         ref_valid = 1'b0;
      end

      @(posedge clk);
      #1;
      check({tag, ".busy"},  DATA_W'(bus.busy),  DATA_W'(ref_clr_left > 0));
      check({tag, ".valid"}, DATA_W'(bus.valid), DATA_W'(ref_valid));
      check({tag, ".dout"},  bus.dout,           ref_dout);
   endtask

   initial begin
      reset        = 1'b1;
      bus.cs       = 1'b0;
      bus.we       = 1'b0;
      bus.addr     = '0;
      bus.din      = '0;
      ref_clr_left = DEPTH;
      ref_dout     = '0;
      ref_valid    = 1'b0;

      // Clear sequence, with a write of F to address 2 presented while busy.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 4'h0, "reset");
      for (int i = 0; i < DEPTH; i++) begin
         if (i < 4) step(1'b0, 1'b1, 1'b1, 4'd2, 4'hF, "busy_wr");
         else       step(1'b0, 1'b0, 1'b0, 4'd0, 4'h0, "clear");
      end
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, ADDR_W'(i), 4'h0, "clr_rd");
      step(1'b0, 1'b0, 1'b0, 4'd0, 4'h0, "clr_rd_end");

      // Write/read-back, then write-then-read on consecutive edges.
      step(1'b0, 1'b1, 1'b1, 4'd3,  4'hA, "wr3");
      step(1'b0, 1'b1, 1'b1, 4'd15, 4'h5, "wr15");
      step(1'b0, 1'b1, 1'b0, 4'd3,  4'h0, "rd3");
      step(1'b0, 1'b0, 1'b0, 4'd0,  4'h0, "gap");
      step(1'b0, 1'b1, 1'b0, 4'd15, 4'h0, "rd15");
      step(1'b0, 1'b0, 1'b0, 4'd0,  4'h0, "gap");
      step(1'b0, 1'b1, 1'b1, 4'd7,  4'hC, "wr7");
      step(1'b0, 1'b1, 1'b0, 4'd7,  4'h0, "rd7_b2b");

      // Idle hold keeps the last read data.
      step(1'b0, 1'b1, 1'b0, 4'd3, 4'h0, "rd3_hold");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd3, 4'h6, "idle_hold");

      // Reset mid-clear restarts the full clear and wipes earlier data.
      step(1'b0, 1'b1, 1'b1, 4'd12, 4'h9, "wr12");
      step(1'b0, 1'b1, 1'b0, 4'd12, 4'h0, "rd12");
      step(1'b1, 1'b0, 1'b0, 4'd0,  4'h0, "reset2");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'd12, 4'h0, "clear2");
      step(1'b1, 1'b1, 1'b1, 4'd12, 4'h7, "reset_mid");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 4'd12, 4'h0, "clear3");
      step(1'b0, 1'b1, 1'b0, 4'd12, 4'h0, "rd12_cleared");

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
              ADDR_W'($urandom), DATA_W'($urandom), "rand");
      end
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'h0, "drain");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, ADDR_W'(i), 4'h0, "final_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ram_sync_clr.md
# ram_sync_clr

Parametrised single-port synchronous RAM that replaces the asynchronous, tri-state RAM in the memory subsystem. It separates the data bus into `din`/`dout`, registers reads with a one-cycle `valid` strobe, and runs a hardware clear sequence after reset that zeroes every word. It sits between the address/control logic and the datapath wherever a word-addressed scratch memory is needed.

## Interface

Parameters:
- `ADDR_W`, default 12: address width.
- `DATA_W`, default 4: word width.
- `DEPTH`, default 2**ADDR_W: number of words. Legal range is 2 to 2**ADDR_W.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `cs`  in  1  Chip select; a request is presented when high.
- `we`  in  1  Write enable; 1 = write, 0 = read (only when `cs`=1).
- `addr`  in  ADDR_W  Word address.
- `din`  in  DATA_W  Write data.
- `dout`  out  DATA_W  Registered read data.
- `valid`  out  1  One-cycle strobe: `dout` holds fresh read data.
- `busy`  out  1  High during reset and the clear sequence; requests are ignored.

## Operation

- FSM states:
  - CLEAR: entered on any clock edge with `reset`=1.
  - IDLE: normal operation.
- CLEAR:
  - While `reset`=1, the clear counter is held at 0 and no writes occur.
  - Each edge with `reset`=0 writes 0 to `mem[clr_cnt]` and increments `clr_cnt`.
  - On the edge that writes `DEPTH-1`, the FSM moves to IDLE.
- In IDLE, on an edge with `cs`=1:
  - Write (`we`=1): `mem[addr]` <= `din`. `dout` is unchanged and `valid` <= 0.
  - Read (`we`=0): `dout` <= `mem[addr]` and `valid` <= 1.
- In IDLE, on an edge with `cs`=0: `valid` <= 0 and `dout` holds.
- Requests while `busy`=1 are ignored:
  - No memory change.
  - `valid` stays 0.
  - `dout` stays 0.
- Out-of-range address (`addr` >= `DEPTH`):
  - Write is dropped.
  - Read returns 0 with `valid`=1.
- Back-to-back accesses are allowed every cycle; there are no wait states in IDLE.

## Timing

- Reset values (after any edge with `reset`=1):
  - `dout`=0, `valid`=0, `busy`=1.
  - FSM=CLEAR, `clr_cnt`=0.
- `busy` stays high for exactly DEPTH edges after the first edge with `reset`=0.
  - It falls on the edge that clears the last word, so the first accepted request is sampled DEPTH+1 edges after reset release.
- Reset asserted mid-clear or mid-operation: the clear restarts from word 0 and the full DEPTH-edge sequence is repeated.
- Read latency is 1 cycle:
  - A request sampled at edge N gives `dout`/`valid` visible after edge N.
  - `valid` falls at edge N+1 unless another read is sampled there.
- Write is visible to a read sampled on the next edge. Write at N to A, then read at N+1 from A, returns the new data after N+1.
- Single port, so simultaneous read and write is impossible; `we` selects one.
- `busy` is a registered output, derived from the FSM state. It is not combinational from `reset`.

## Test plan

Bench parameters: `ADDR_W`=4, `DATA_W`=4, `DEPTH`=16.

1. Clear sequence:
   - Stimulus: hold `reset` 3 cycles, then release; after `busy` falls, read all 16 addresses.
   - Required: `busy` high for exactly 16 edges after release; every read gives `dout`=0 with `valid`=1 one cycle after each request.
2. Write/read-back:
   - Stimulus: write A=3 with 4'hA, then A=15 with 4'h5; read A=3, then A=15.
   - Required: `dout`=4'hA, then 4'h5, each with a one-cycle `valid` pulse.
3. Back-to-back:
   - Stimulus: write A=7 with 4'hC at edge N; read A=7 at edge N+1.
   - Required: after N+1, `dout`=4'hC and `valid`=1.
4. Requests during busy:
   - Stimulus: present a write of 4'hF to A=2 during CLEAR; after `busy` falls, read A=2.
   - Required: `valid` stays 0 during CLEAR; the read returns 0.
5. Reset mid-clear:
   - Stimulus: assert `reset` at clear step 8 for 1 cycle.
   - Required: `busy` stays high a further 16 edges after release; a previously written value at A=12 reads 0.
6. Idle hold:
   - Stimulus: read A=3 (value 4'hA), then hold `cs`=0 for 4 cycles.
   - Required: `valid`=0 during the hold; `dout` stays 4'hA.
